// File: rtl/pattern_generator.sv
// -----------------------------------------------------------------------------
// pattern_generator
//   Transmit-side training pattern source for 16 mainband lanes. Sends one
//   WIDTH-bit word per lane per handshake: per-lane PRBS23 data in
//   PATTERN_LFSR mode, or the per-lane ID word in PER_LANE_IDE mode.
//   The receive side uses a second copy as its local reference, so all state
//   is a pure function of reset and the control inputs.
//
// Ports
//   i_clk        clock
//   i_rst_n      asynchronous active-low reset
//   i_state[1:0] training state: 00 IDLE, 01 CLEAR_LFSR, 10 PATTERN_LFSR,
//                11 PER_LANE_IDE
//   i_start      one-cycle burst start request
//   i_burst_len  words in the burst, sampled at start
//   i_ready      serializer accepts the current word
//   o_valid      o_tx_data holds a word
//   o_tx_data    lane n at [n*WIDTH +: WIDTH]
//   o_busy       burst in progress
//   o_done       one-cycle pulse when a burst completes
// -----------------------------------------------------------------------------

// Per-lane PRBS23 (x^23+x^21+x^18+x^15+x^7+x^2+1, Fibonacci) plus the lane's
// registered output word.
//   i_reseed  load seed, zero word (wins over everything else)
//   i_load    load a new word (current LFSR word, or post-advance word)
//   i_advance step the LFSR 32 times
//   i_zero    zero the word (end of burst)
//   i_mode_id select lane ID word instead of PRBS
module pattern_generator_lane #(
   parameter int          WIDTH   = 32,
   parameter logic [22:0] SEED    = 23'h1DBFBC,
   parameter logic [7:0]  LANE_ID = 8'd0
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_reseed,
   input  logic             i_load,
   input  logic             i_advance,
   input  logic             i_zero,
   input  logic             i_mode_id,
   output logic [WIDTH-1:0] o_data
);

   localparam logic [WIDTH-1:0] ID_WORD = {2{4'hA, LANE_ID, 4'hA}};

   logic [22:0]      r_lfsr;
   logic [WIDTH-1:0] r_data;
   logic [22:0]      w_lfsr_adv;
   logic [WIDTH-1:0] w_word_cur;
   logic [WIDTH-1:0] w_word_adv;

   function automatic logic [22:0] lfsr_step(input logic [22:0] s);
      return {s[21:0], s[22] ^ s[20] ^ s[17] ^ s[14] ^ s[6] ^ s[1]};
   endfunction

   // Word bit 0 is the first serial bit (lfsr[22] of the current state).
   function automatic logic [WIDTH-1:0] prbs_word(input logic [22:0] s);
      logic [22:0]      st;
      logic [WIDTH-1:0] w;
      st = s;
      w  = '0;
      for (int k = 0; k < WIDTH; k++) begin
         w[k] = st[22];
         st   = lfsr_step(st);
      end
      return w;
   endfunction

   function automatic logic [22:0] lfsr_adv(input logic [22:0] s);
      logic [22:0] st;
      st = s;
      for (int k = 0; k < WIDTH; k++) st = lfsr_step(st);
      return st;
   endfunction

   assign w_lfsr_adv = lfsr_adv(r_lfsr);
   assign w_word_cur = prbs_word(r_lfsr);
   assign w_word_adv = prbs_word(w_lfsr_adv);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_lfsr <= SEED;
         r_data <= '0;
      end else if (i_reseed) begin
         r_lfsr <= SEED;
         r_data <= '0;
      end else begin
         if (i_advance) r_lfsr <= w_lfsr_adv;
         if (i_zero)
            r_data <= '0;
         else if (i_load)
            // On a transfer the next word comes from the advanced state so
            // there is no bubble between consecutive words.
            r_data <= i_mode_id ? ID_WORD : (i_advance ? w_word_adv : w_word_cur);
      end
   end

   assign o_data = r_data;

endmodule

module pattern_generator #(
   parameter int          WIDTH     = 32,
   // Lane seeds differ only in the low byte; SEED_BASE[22:8] must be nonzero
   // or lane SEED_BASE[7:0] would get the all-zero lock-up seed.
   parameter logic [22:0] SEED_BASE = 23'h1DBFBC
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic [1:0]            i_state,
   input  logic                  i_start,
   input  logic [15:0]           i_burst_len,
   input  logic                  i_ready,
   output logic                  o_valid,
   output logic [16*WIDTH-1:0]   o_tx_data,
   output logic                  o_busy,
   output logic                  o_done
);

   localparam int NUM_LANES = 16;

   localparam logic [1:0] ST_CLEAR = 2'b01;

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2} fsm_t;

   fsm_t        r_fsm;
   logic [15:0] r_cnt;
   logic [15:0] r_len;
   logic        r_mode_id;
   logic        r_valid;
   logic        r_busy;
   logic        r_done;

   logic w_clear;
   logic w_start_ok;
   logic w_xfer;
   logic w_last;
   logic w_load;
   logic w_adv;
   logic w_mode_id;

   logic [NUM_LANES-1:0][WIDTH-1:0] w_lane_data;

   assign w_clear    = (i_state == ST_CLEAR);
   // i_state[1] set means PATTERN_LFSR or PER_LANE_IDE
   assign w_start_ok = (r_fsm == S_IDLE) && i_start && i_state[1];
   assign w_xfer     = (r_fsm == S_RUN) && r_valid && i_ready && !w_clear;
   assign w_last     = w_xfer && (r_cnt == r_len - 16'd1);
   // Mode is taken live at start, from the latched copy during the burst.
   assign w_mode_id  = (r_fsm == S_IDLE) ? i_state[0] : r_mode_id;
   assign w_load     = (w_start_ok && (i_burst_len != 16'd0)) || (w_xfer && !w_last);
   assign w_adv      = w_xfer && !r_mode_id;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_fsm     <= S_IDLE;
         r_cnt     <= '0;
         r_len     <= '0;
         r_mode_id <= 1'b0;
         r_valid   <= 1'b0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
      end else if (w_clear) begin
         // Abort from any state; beats a simultaneous transfer.
         r_fsm   <= S_IDLE;
         r_cnt   <= '0;
         r_valid <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         case (r_fsm)
            S_IDLE: begin
               r_done <= 1'b0;
               if (w_start_ok) begin
                  r_len     <= i_burst_len;
                  r_mode_id <= i_state[0];
                  r_cnt     <= '0;
                  if (i_burst_len == 16'd0) begin
                     r_fsm  <= S_DONE;
                     r_done <= 1'b1;
                  end else begin
                     r_fsm   <= S_RUN;
                     r_valid <= 1'b1;
                     r_busy  <= 1'b1;
                  end
               end
            end
            S_RUN: begin
               if (w_xfer) begin
                  r_cnt <= r_cnt + 16'd1;
                  if (w_last) begin
                     r_fsm   <= S_DONE;
                     r_valid <= 1'b0;
                     r_busy  <= 1'b0;
                     r_done  <= 1'b1;
                  end
               end
            end
            S_DONE: begin
               r_done <= 1'b0;
               r_fsm  <= S_IDLE;
            end
            default: begin
               r_fsm   <= S_IDLE;
               r_valid <= 1'b0;
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
            end
         endcase
      end
   end

   for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
      pattern_generator_lane #(
         .WIDTH   (WIDTH),
         .SEED    ({SEED_BASE[22:8], SEED_BASE[7:0] ^ 8'(g)}),
         .LANE_ID (8'(g))
      ) u_lane (
         .i_clk     (i_clk),
         .i_rst_n   (i_rst_n),
         .i_reseed  (w_clear),
         .i_load    (w_load),
         .i_advance (w_adv),
         .i_zero    (w_last),
         .i_mode_id (w_mode_id),
         .o_data    (w_lane_data[g])
      );
   end

   assign o_tx_data = w_lane_data;
   assign o_valid   = r_valid;
   assign o_busy    = r_busy;
   assign o_done    = r_done;

endmodule

// File: tb/tb_pattern_generator.sv
module tb_pattern_generator;

   localparam logic [22:0] SEED   = 23'h1DBFBC;
   localparam logic [1:0]  ST_IDL = 2'b00;
   localparam logic [1:0]  ST_CLR = 2'b01;
   localparam logic [1:0]  ST_PAT = 2'b10;
   localparam logic [1:0]  ST_IDE = 2'b11;

   logic          clk = 0;
   logic          rst_n = 0;
   logic [1:0]    i_state = ST_IDL;
   logic          i_start = 0;
   logic [15:0]   i_burst_len = 0;
   logic          i_ready = 0;
   logic          o_valid;
   logic [511:0]  o_tx_data;
   logic          o_busy;
   logic          o_done;

   pattern_generator dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_state(i_state), .i_start(i_start),
      .i_burst_len(i_burst_len), .i_ready(i_ready), .o_valid(o_valid),
      .o_tx_data(o_tx_data), .o_busy(o_busy), .o_done(o_done)
   );

   always #5 clk = ~clk;

   int n_cmp = 0, n_bad = 0;
   int xfer_cnt = 0, done_cnt = 0, valid_cyc = 0;
   int rdy_mode = 0;   // 0 always ready, 1 random, 2 pattern 1,0,0
   int rdy_ph = 0;
   logic [511:0] exp_q[$];
   logic [22:0]  mdl[16];

   task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   // ---------------- reference model: serial PRBS per lane ----------------
   function automatic void mdl_reseed();
      for (int l = 0; l < 16; l++) begin
         logic [7:0] lb;
         lb = 8'(l);
         mdl[l] = {SEED[22:8], SEED[7:0] ^ lb};
      end
   endfunction

   function automatic logic mdl_bit(input int l);
      logic b;
      b = mdl[l][22];
      mdl[l] = {mdl[l][21:0], mdl[l][22]^mdl[l][20]^mdl[l][17]^mdl[l][14]^mdl[l][6]^mdl[l][1]};
      return b;
   endfunction

   function automatic logic [511:0] mdl_word(input logic id_mode);
      logic [511:0] w;
      w = '0;
      for (int l = 0; l < 16; l++) begin
         if (id_mode) begin
            logic [7:0] lb;
            lb = 8'(l);
            w[l*32 +: 32] = {4'hA, lb, 4'hA, 4'hA, lb, 4'hA};
         end else
            for (int k = 0; k < 32; k++) w[l*32 + k] = mdl_bit(l);
      end
      return w;
   endfunction

   // ---------------- ready driver ----------------
   always @(posedge clk) begin
      #1;
      case (rdy_mode)
         0: i_ready = 1'b1;
         1: i_ready = 1'($urandom % 2);
         default: begin
            i_ready = (rdy_ph == 0);
            rdy_ph  = (rdy_ph + 1) % 3;
         end
      endcase
   end

   // ---------------- monitor / scoreboard ----------------
   logic         prev_v = 0, prev_x = 0;
   logic [511:0] prev_d = '0;
   always @(negedge clk) begin
      logic x;
      if (rst_n) begin
         x = o_valid && i_ready && (i_state != ST_CLR);
         if (prev_v && !prev_x && o_valid) chk("stall_stable", o_tx_data, prev_d);
         if (o_valid) begin
            valid_cyc++;
            chk("busy_with_valid", 512'(o_busy), 512'(1));
         end
         if (x) begin
            xfer_cnt++;
            if (exp_q.size() == 0) chk("unexpected_word", 512'(o_valid), 512'(0));
            else chk("word", o_tx_data, exp_q.pop_front());
         end
         if (o_done) begin
            done_cnt++;
            chk("done_no_valid", {o_valid, o_busy}, 512'(0));
         end
         prev_v = o_valid; prev_x = x; prev_d = o_tx_data;
      end else begin
         prev_v = 0; prev_x = 0;
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic do_clear();
      @(posedge clk); #1 i_state = ST_CLR;
      @(posedge clk); #1 i_state = ST_PAT;
      mdl_reseed();
   endtask

   task automatic burst(input logic [1:0] st, input int len, input bit chk_rev, input bit toggle);
      int d0, v0, cyc;
      logic [22:0] sd, rv;
      for (int i = 0; i < len; i++) exp_q.push_back(mdl_word(st[0]));
      d0 = done_cnt;
      @(posedge clk); #1 i_state = st; i_start = 1; i_burst_len = 16'(len);
      v0 = valid_cyc;
      @(posedge clk); #1 i_start = 0;
      @(negedge clk);
      chk("first_valid", 512'(o_valid), 512'(len != 0));
      if (len == 0) chk("len0_done", 512'(o_done), 512'(1));
      if (chk_rev) begin
         sd = SEED;
         for (int k = 0; k < 23; k++) rv[k] = sd[22-k];
         chk("lane0_bitrev", 512'(o_tx_data[22:0]), 512'(rv));
      end
      if (st == ST_IDE && len > 0) begin
         chk("lane5_id",  512'(o_tx_data[5*32 +: 32]),  512'(32'hA05AA05A));
         chk("lane15_id", 512'(o_tx_data[15*32 +: 32]), 512'(32'hA0FAA0FA));
      end
      cyc = 0;
      while (done_cnt == d0 && cyc < len*4 + 40) begin
         @(posedge clk); #1;
         cyc++;
         if (toggle && cyc == 3) i_state = st ^ 2'b01;
      end
      i_state = st;
      chk("done_seen", 512'(done_cnt), 512'(d0 + 1));
      chk("queue_drained", 512'(exp_q.size()), 512'(0));
      if (rdy_mode == 0) chk("valid_cycles", 512'(valid_cyc - v0), 512'(len));
      @(negedge clk);
      chk("post_burst_idle", {o_tx_data, o_valid, o_busy, o_done}, '0);
      exp_q.delete();
   endtask

   // ---------------- main sequence ----------------
   initial begin
      int x0, d0, cyc;
      mdl_reseed();
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_outputs", {o_tx_data, o_valid, o_busy, o_done}, '0);
      @(posedge clk); #1 rst_n = 1;

      do_clear();
      // basic LFSR burst
      burst(ST_PAT, 4, 1, 0);
      // lane ID burst
      burst(ST_IDE, 128, 0, 0);
      // stalls 1,0,0 on a fresh sequence
      do_clear();
      rdy_mode = 2; rdy_ph = 0;
      burst(ST_PAT, 8, 0, 0);
      rdy_mode = 0;
      // continuation across bursts, then reseed
      do_clear();
      burst(ST_PAT, 4, 0, 0);
      burst(ST_PAT, 4, 0, 0);
      do_clear();
      burst(ST_PAT, 4, 1, 0);

      // abort with CLEAR_LFSR after 10 transfers
      for (int i = 0; i < 100; i++) exp_q.push_back(mdl_word(1'b0));
      x0 = xfer_cnt; d0 = done_cnt;
      @(posedge clk); #1 i_state = ST_PAT; i_start = 1; i_burst_len = 16'd100;
      @(posedge clk); #1 i_start = 0;
      cyc = 0;
      while (xfer_cnt < x0 + 10 && cyc < 60) begin @(posedge clk); #1; cyc++; end
      i_state = ST_CLR;
      @(posedge clk);
      @(negedge clk);
      chk("abort_outputs", {o_valid, o_busy, o_done}, '0);
      chk("abort_xfers", 512'(xfer_cnt - x0), 512'(10));
      exp_q.delete();
      mdl_reseed();
      @(posedge clk); #1 i_state = ST_PAT;
      repeat (3) @(posedge clk);
      chk("abort_no_done", 512'(done_cnt), 512'(d0));
      burst(ST_PAT, 4, 1, 0);

      // zero-length burst
      burst(ST_PAT, 0, 0, 0);

      // start while i_state is IDLE is ignored
      d0 = done_cnt;
      @(posedge clk); #1 i_state = ST_IDL; i_start = 1; i_burst_len = 16'd5;
      @(posedge clk); #1 i_start = 0;
      repeat (4) @(posedge clk);
      @(negedge clk);
      chk("idle_start_ignored", {o_valid, o_busy, o_done}, '0);
      chk("idle_start_no_done", 512'(done_cnt), 512'(d0));

      // mode change mid-burst is ignored
      burst(ST_PAT, 12, 0, 1);
      burst(ST_IDE, 6, 0, 1);

      // randomized bursts with random backpressure
      rdy_mode = 1;
      for (int b = 0; b < 20; b++) begin
         if ($urandom_range(0, 5) == 0) do_clear();
         burst(($urandom % 2) ? ST_IDE : ST_PAT, int'($urandom_range(1, 40)), 0, 0);
      end
      rdy_mode = 0;

      // async reset mid-burst
      for (int i = 0; i < 20; i++) exp_q.push_back(mdl_word(1'b0));
      x0 = xfer_cnt;
      @(posedge clk); #1 i_state = ST_PAT; i_start = 1; i_burst_len = 16'd20;
      @(posedge clk); #1 i_start = 0;
      cyc = 0;
      while (xfer_cnt < x0 + 5 && cyc < 40) begin @(posedge clk); #1; cyc++; end
      #2 rst_n = 0;
      #1;
      chk("async_reset_outputs", {o_tx_data, o_valid, o_busy, o_done}, '0);
      exp_q.delete();
      mdl_reseed();
      @(posedge clk); #1 rst_n = 1;
      burst(ST_PAT, 4, 1, 0);

      repeat (3) @(posedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout want completion");
      $fatal(1);
   end

endmodule
